// File: rtl/l15_store_pkg.sv
// Shared types and helpers for the L1.5 store-issue stage.
package l15_store_pkg;

  // Field widths of the registered output request (match the default top parameters).
  localparam int unsigned StAddrW = 64;
  localparam int unsigned StTidW  = 3;

  typedef enum logic [1:0] {
    StRun,
    StNiWait,
    StFence
  } state_e;

  typedef struct packed {
    logic [StAddrW-1:0] addr;
    logic [63:0]        data;
    logic [7:0]         be;
    logic [1:0]         size;
    logic [StTidW-1:0]  tid;
    logic               nc;
  } out_req_t;

  // Unsigned window test; a zero length disables the region.
  function automatic logic in_nonidem(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] len);
    return (len != 64'h0) && (addr >= base) && ((addr - base) < len);
  endfunction

endpackage

// File: rtl/l15_store_issue_if.sv
// Store-issue bus bundle: upstream request, downstream L1.5 request, acks and fence.
interface l15_store_issue_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TID_WIDTH  = 3
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic [7:0]            req_be_i;
  logic [1:0]            req_size_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [ADDR_WIDTH-1:0] out_addr_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic [7:0]            out_be_o;
  logic [1:0]            out_size_o;
  logic [TID_WIDTH-1:0]  out_tid_o;
  logic                  out_nc_o;
  logic                  ack_valid_i;
  logic [TID_WIDTH-1:0]  ack_tid_i;
  logic                  fence_i;
  logic                  fence_done_o;
  logic                  empty_o;
  logic [TID_WIDTH:0]    outstanding_o;
  logic                  spurious_ack_o;

  // Store-issue stage side.
  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_be_i, req_size_i,
    input  out_ready_i, ack_valid_i, ack_tid_i, fence_i,
    output req_ready_o, out_valid_o, out_addr_o, out_data_o, out_be_o, out_size_o,
    output out_tid_o, out_nc_o, fence_done_o, empty_o, outstanding_o, spurious_ack_o
  );

  // Environment side (write buffer, L1.5 adapter).
  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_be_i, req_size_i,
    output out_ready_i, ack_valid_i, ack_tid_i, fence_i,
    input  req_ready_o, out_valid_o, out_addr_o, out_data_o, out_be_o, out_size_o,
    input  out_tid_o, out_nc_o, fence_done_o, empty_o, outstanding_o, spurious_ack_o
  );
endinterface

// File: rtl/l15_tid_alloc.sv
// TID allocator: busy bitmap, lowest-free pick, in-flight count, spurious-ack flag.
module l15_tid_alloc #(
  parameter int unsigned TID_WIDTH       = 3,
  parameter int unsigned MAX_OUTSTANDING = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alloc_i,
  input  logic                 ack_valid_i,
  input  logic [TID_WIDTH-1:0] ack_tid_i,
  output logic                 full_o,
  output logic [TID_WIDTH-1:0] free_tid_o,
  output logic [TID_WIDTH:0]   outstanding_o,
  output logic                 spurious_ack_o
);

  logic [MAX_OUTSTANDING-1:0] busy_q, busy_d;
  logic [TID_WIDTH:0]         count_q, count_d;
  logic                       spurious_q;
  logic                       ack_hit;

  // Lowest-index free TID; scan downwards so the lowest match wins.
  always_comb begin
    full_o     = 1'b1;
    free_tid_o = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        full_o     = 1'b0;
        free_tid_o = TID_WIDTH'(i);
      end
    end
  end

  // Bitmap and count update; an ack only frees a TID that is currently busy.
  always_comb begin
    busy_d  = busy_q;
    ack_hit = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (alloc_i && !full_o && (free_tid_o == TID_WIDTH'(i))) busy_d[i] = 1'b1;
      if (ack_valid_i && (ack_tid_i == TID_WIDTH'(i)) && busy_q[i]) begin
        busy_d[i] = 1'b0;
        ack_hit   = 1'b1;
      end
    end
    count_d = count_q + (TID_WIDTH + 1)'(alloc_i && !full_o) - (TID_WIDTH + 1)'(ack_hit);
  end

  // Registered state; freed TIDs become allocatable the following cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      count_q    <= count_d;
      spurious_q <= ack_valid_i && !ack_hit;
    end
  end

  assign outstanding_o  = count_q;
  assign spurious_ack_o = spurious_q;

endmodule

// File: rtl/l15_store_issue.sv
// Store-issue stage between the dcache write buffer and the L1.5 NoC adapter.
// Optional: define L15_STORE_BIG_ENDIAN_EN to byte-swap data and byte-enables.
module l15_store_issue
  import l15_store_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned TID_WIDTH       = 3,
  parameter int unsigned MAX_OUTSTANDING = 7,
  parameter logic [63:0] NONIDEM_BASE    = 64'h0,
  parameter logic [63:0] NONIDEM_LEN     = 64'h8000_0000
) (
  input logic              clk_i,
  input logic              rst_i,
  l15_store_issue_if.slave bus
);

  state_e                  state_q;
  logic                    fence_done_q;
  out_req_t                out_q;
  logic                    out_valid_q;
  logic                    full;
  logic [TID_WIDTH-1:0]    free_tid;
  logic [TID_WIDTH:0]      outstanding;
  logic                    spurious;
  logic                    nonidem, empty, nc_ok, out_free, req_ready, accept;
  logic [DATA_WIDTH-1:0]   data_conv;
  logic [7:0]              be_conv;

  assign nonidem   = in_nonidem(64'(bus.req_addr_i), NONIDEM_BASE, NONIDEM_LEN);
  assign empty     = (outstanding == '0) && !out_valid_q;
  assign nc_ok     = !nonidem || empty;
  assign out_free  = !out_valid_q || bus.out_ready_i;
  // A same-cycle fence blocks acceptance.
  assign req_ready = (state_q == StRun) && !bus.fence_i && out_free && !full && nc_ok;
  assign accept    = bus.req_valid_i && req_ready;

  // Endian stage applied on the way into the output register.
  always_comb begin
    data_conv = bus.req_data_i;
    be_conv   = bus.req_be_i;
`ifdef L15_STORE_BIG_ENDIAN_EN
    for (int i = 0; i < 8; i++) begin
      data_conv[8*i +: 8] = bus.req_data_i[8*(7-i) +: 8];
      be_conv[i]          = bus.req_be_i[7-i];
    end
`endif
  end

  l15_tid_alloc #(
    .TID_WIDTH       (TID_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_tid_alloc (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alloc_i        (accept),
    .ack_valid_i    (bus.ack_valid_i),
    .ack_tid_i      (bus.ack_tid_i),
    .full_o         (full),
    .free_tid_o     (free_tid),
    .outstanding_o  (outstanding),
    .spurious_ack_o (spurious)
  );

  // Output register: load on accept, hold until the adapter takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q.addr  <= StAddrW'(bus.req_addr_i);
      out_q.data  <= 64'(data_conv);
      out_q.be    <= be_conv;
      out_q.size  <= bus.req_size_i;
      out_q.tid   <= StTidW'(free_tid);
      out_q.nc    <= nonidem;
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  // Control FSM: non-idempotent serialisation and fence drain with a registered done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StRun;
      fence_done_q <= 1'b0;
    end else begin
      fence_done_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (bus.fence_i) begin
            if (empty) fence_done_q <= 1'b1;
            else       state_q      <= StFence;
          end else if (bus.req_valid_i && !nc_ok) begin
            state_q <= StNiWait;
          end
        end
        StNiWait: if (empty) state_q <= StRun;
        StFence: begin
          if (empty) begin
            fence_done_q <= 1'b1;
            state_q      <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.req_ready_o    = req_ready;
  assign bus.out_valid_o    = out_valid_q;
  assign bus.out_addr_o     = ADDR_WIDTH'(out_q.addr);
  assign bus.out_data_o     = DATA_WIDTH'(out_q.data);
  assign bus.out_be_o       = out_q.be;
  assign bus.out_size_o     = out_q.size;
  assign bus.out_tid_o      = TID_WIDTH'(out_q.tid);
  assign bus.out_nc_o       = out_q.nc;
  assign bus.fence_done_o   = fence_done_q;
  assign bus.empty_o        = empty;
  assign bus.outstanding_o  = outstanding;
  assign bus.spurious_ack_o = spurious;

endmodule

// File: tb/tb_l15_store_issue.sv
// Directed bench for l15_store_issue: vector table plus hand-written corner sequences.
module tb_l15_store_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  l15_store_issue_if bus ();

  l15_store_issue dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  localparam logic [63:0] A = 64'h9000_0000;

  typedef struct {
    logic        v;
    logic [63:0] addr;
    logic        ordy;
    logic        av;
    logic [2:0]  at;
    logic        f;
    logic        e_rdy;
    logic        e_oval;
    logic [2:0]  e_tid;
    logic [3:0]  e_out;
    logic        e_empty;
    logic        e_spur;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [63:0] addr, input logic ordy,
                              input logic av, input logic [2:0] at, input logic f,
                              input logic e_rdy, input logic e_oval, input logic [2:0] e_tid,
                              input logic [3:0] e_out, input logic e_empty, input logic e_spur);
    vec_t r;
    r.v = v; r.addr = addr; r.ordy = ordy; r.av = av; r.at = at; r.f = f;
    r.e_rdy = e_rdy; r.e_oval = e_oval; r.e_tid = e_tid; r.e_out = e_out;
    r.e_empty = e_empty; r.e_spur = e_spur;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs at the falling edge; combinational outputs are valid #1 later.
  task automatic drive(input logic v, input logic [63:0] addr, input logic ordy,
                       input logic av, input logic [2:0] at, input logic f);
    @(negedge clk);
    bus.req_valid_i = v;
    bus.req_addr_i  = addr;
    bus.out_ready_i = ordy;
    bus.ack_valid_i = av;
    bus.ack_tid_i   = at;
    bus.fence_i     = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] exp_data;
  logic [7:0]  exp_be;
  logic        got;

  initial begin
`ifdef L15_STORE_BIG_ENDIAN_EN
    exp_data = 64'h7766_5544_3322_1100;
    exp_be   = 8'hF0;
`else
    exp_data = 64'h0011_2233_4455_6677;
    exp_be   = 8'h0F;
`endif
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = 64'h0011_2233_4455_6677;
    bus.req_be_i    = 8'h0F;
    bus.req_size_i  = 2'd3;
    bus.out_ready_i = 1'b1;
    bus.ack_valid_i = 1'b0;
    bus.ack_tid_i   = '0;
    bus.fence_i     = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_outstanding", bus.outstanding_o, 0);
    chk("rst_empty", bus.empty_o, 1);
    chk("rst_fence_done", bus.fence_done_o, 0);
    chk("rst_spurious", bus.spurious_ack_o, 0);
    chk("rst_out_data", bus.out_data_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single store, latency 1, endian stage.
    drive(1, 64'h8000_0000, 1, 0, 0, 0);
    chk("t1_ready", bus.req_ready_o, 1);
    tick();
    chk("t1_out_valid", bus.out_valid_o, 1);
    chk("t1_tid", bus.out_tid_o, 0);
    chk("t1_nc", bus.out_nc_o, 0);
    chk("t1_outstanding", bus.outstanding_o, 1);
    chk("t1_addr", bus.out_addr_o, 64'h8000_0000);
    chk("t1_data", bus.out_data_o, exp_data);
    chk("t1_be", bus.out_be_o, exp_be);
    chk("t1_size", bus.out_size_o, 3);
    drive(0, A, 1, 1, 0, 0);
    tick();
    chk("t1_ack_outstanding", bus.outstanding_o, 0);
    chk("t1_ack_empty", bus.empty_o, 1);

    // Vector table: fill to full, ack-then-reuse, drain, spurious and same-cycle acks.
    for (int k = 0; k < 7; k++) tbl.push_back(mk(1, A, 1, 0, 0, 0, 1, 1, 3'(k), 4'(k + 1), 0, 0));
    tbl.push_back(mk(1, A, 1, 0, 0, 0, 0, 0, 0, 7, 0, 0));
    tbl.push_back(mk(1, A, 1, 1, 3, 0, 0, 0, 0, 6, 0, 0));
    tbl.push_back(mk(1, A, 1, 0, 0, 0, 1, 1, 3, 7, 0, 0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(0, A, 1, 1, 3'(k), 0, k != 0, 0, 0, 4'(6 - k), k == 6, 0));
    tbl.push_back(mk(1, A, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, A, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, A, 1, 1, 5, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, A, 1, 1, 7, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, A, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, A, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].addr, tbl[i].ordy, tbl[i].av, tbl[i].at, tbl[i].f);
      chk($sformatf("v%0d_ready", i), bus.req_ready_o, tbl[i].e_rdy);
      tick();
      chk($sformatf("v%0d_out_valid", i), bus.out_valid_o, tbl[i].e_oval);
      if (tbl[i].e_oval) chk($sformatf("v%0d_tid", i), bus.out_tid_o, tbl[i].e_tid);
      chk($sformatf("v%0d_outstanding", i), bus.outstanding_o, tbl[i].e_out);
      chk($sformatf("v%0d_empty", i), bus.empty_o, tbl[i].e_empty);
      chk($sformatf("v%0d_spurious", i), bus.spurious_ack_o, tbl[i].e_spur);
    end

    // Non-idempotent store with two in flight waits for both acks.
    drive(1, A, 1, 0, 0, 0);
    tick();
    drive(1, A, 1, 0, 0, 0);
    tick();
    chk("ni_pre_outstanding", bus.outstanding_o, 2);
    drive(1, 64'h1000, 1, 0, 0, 0);
    chk("ni_ready0", bus.req_ready_o, 0);
    tick();
    drive(1, 64'h1000, 1, 1, 0, 0);
    chk("ni_ready1", bus.req_ready_o, 0);
    tick();
    drive(1, 64'h1000, 1, 1, 1, 0);
    chk("ni_ready2", bus.req_ready_o, 0);
    tick();
    chk("ni_drained", bus.outstanding_o, 0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      drive(1, 64'h1000, 1, 0, 0, 0);
      if (bus.req_ready_o) got = 1'b1;
      tick();
    end
    chk("ni_accepted", got, 1);
    chk("ni_out_nc", bus.out_nc_o, 1);
    chk("ni_out_addr", bus.out_addr_o, 64'h1000);
    chk("ni_out_tid", bus.out_tid_o, 0);
    drive(0, A, 1, 1, 0, 0);
    tick();
    chk("ni_clear", bus.outstanding_o, 0);

    // Fence with three outstanding.
    for (int k = 0; k < 3; k++) begin
      drive(1, A, 1, 0, 0, 0);
      tick();
    end
    chk("f_pre_outstanding", bus.outstanding_o, 3);
    drive(0, A, 1, 0, 0, 1);
    chk("f_ready_fence", bus.req_ready_o, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, A, 1, 1, 3'(k), 0);
      chk($sformatf("f_ready_ack%0d", k), bus.req_ready_o, 0);
      tick();
      chk($sformatf("f_done_ack%0d", k), bus.fence_done_o, 0);
      chk($sformatf("f_out_ack%0d", k), bus.outstanding_o, 2 - k);
    end
    drive(0, A, 1, 0, 0, 0);
    chk("f_ready_drained", bus.req_ready_o, 0);
    tick();
    chk("f_done_pulse", bus.fence_done_o, 1);
    drive(0, A, 1, 0, 0, 0);
    chk("f_ready_after", bus.req_ready_o, 1);
    tick();
    chk("f_done_low", bus.fence_done_o, 0);

    // Fence while empty wins over a same-cycle request.
    drive(1, A, 1, 0, 0, 1);
    chk("fe_ready", bus.req_ready_o, 0);
    tick();
    chk("fe_done", bus.fence_done_o, 1);
    chk("fe_no_accept", bus.outstanding_o, 0);
    drive(0, A, 1, 0, 0, 0);
    tick();
    chk("fe_done_low", bus.fence_done_o, 0);

    // Output stall: held stable for four cycles.
    drive(1, A, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, A + 64'h8, 0, 0, 0, 0);
      chk($sformatf("st_ready%0d", k), bus.req_ready_o, 0);
      tick();
      chk($sformatf("st_valid%0d", k), bus.out_valid_o, 1);
      chk($sformatf("st_addr%0d", k), bus.out_addr_o, A);
      chk($sformatf("st_tid%0d", k), bus.out_tid_o, 0);
      chk($sformatf("st_out%0d", k), bus.outstanding_o, 1);
    end
    drive(1, A + 64'h8, 1, 0, 0, 0);
    chk("st_release_ready", bus.req_ready_o, 1);
    tick();
    chk("st_second_addr", bus.out_addr_o, A + 64'h8);
    chk("st_second_tid", bus.out_tid_o, 1);
    chk("st_second_out", bus.outstanding_o, 2);

    // Reset mid-stream, then a stale ack is spurious.
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    tick();
    chk("mr_out_valid", bus.out_valid_o, 0);
    chk("mr_outstanding", bus.outstanding_o, 0);
    chk("mr_empty", bus.empty_o, 1);
    @(negedge clk);
    rst = 1'b0;
    drive(0, A, 1, 1, 0, 0);
    tick();
    chk("mr_stale_spurious", bus.spurious_ack_o, 1);
    chk("mr_stale_out", bus.outstanding_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
